// File: rtl/window_stats_tracker.sv
// Per-window min/max/exact-sum tracker over a signed 8-bit sample stream.
// Completed records go through a 2-entry FIFO with valid/ready; overflow records are counted.
module window_stats_tracker #(
  parameter  int WINDOW = 16,
  localparam int SUM_W  = 8 + $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [7:0]       in_sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_min,
  output logic [7:0]       out_max,
  output logic [SUM_W-1:0] out_sum,
  output logic [7:0]       drop_count,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  // Handshake: a record moves to the consumer on a rising edge where
  // en && out_valid && out_ready; out_valid never depends on out_ready.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } buf_state_t;

  buf_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_min_acc;
  logic [7:0]       r_max_acc;
  logic [SUM_W-1:0] r_sum_acc;

  // Head entry doubles as the output register so fields hold after the last pop.
  logic [7:0]       r_head_min;
  logic [7:0]       r_head_max;
  logic [SUM_W-1:0] r_head_sum;
  logic [7:0]       r_tail_min;
  logic [7:0]       r_tail_max;
  logic [SUM_W-1:0] r_tail_sum;
  logic [7:0]       r_drop_count;

  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic             w_complete;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [SUM_W-1:0] w_sample_ext;
  logic [7:0]       w_new_min;
  logic [7:0]       w_new_max;
  logic [SUM_W-1:0] w_new_sum;

  assign w_accept     = en && in_valid;
  assign w_first      = (r_cnt == '0);
  assign w_last       = (r_cnt == CNT_W'(WINDOW - 1));
  assign w_complete   = w_accept && w_last;
  assign w_sample_ext = {{(SUM_W-8){in_sample[7]}}, in_sample};

  always_comb begin
    w_new_min = in_sample;
    w_new_max = in_sample;
    w_new_sum = w_sample_ext;
    if (!w_first) begin
      w_new_min = ($signed(in_sample) < $signed(r_min_acc)) ? in_sample : r_min_acc;
      w_new_max = ($signed(in_sample) > $signed(r_max_acc)) ? in_sample : r_max_acc;
      w_new_sum = r_sum_acc + w_sample_ext;
    end
  end

  assign w_pop  = en && (r_state != S_EMPTY) && out_ready;
  assign w_push = w_complete && ((r_state != S_FULL) || w_pop);
  assign w_drop = w_complete && !w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_min_acc <= '0;
      r_max_acc <= '0;
      r_sum_acc <= '0;
    end else if (w_accept) begin
      r_min_acc <= w_new_min;
      r_max_acc <= w_new_max;
      r_sum_acc <= w_new_sum;
      r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_head_min <= '0;
      r_head_max <= '0;
      r_head_sum <= '0;
      r_tail_min <= '0;
      r_tail_max <= '0;
      r_tail_sum <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_head_min <= w_new_min;
            r_head_max <= w_new_max;
            r_head_sum <= w_new_sum;
            r_state    <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            r_head_min <= w_new_min;
            r_head_max <= w_new_max;
            r_head_sum <= w_new_sum;
          end else if (w_push) begin
            r_tail_min <= w_new_min;
            r_tail_max <= w_new_max;
            r_tail_sum <= w_new_sum;
            r_state    <= S_FULL;
          end else if (w_pop) begin
            r_state    <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            r_head_min <= r_tail_min;
            r_head_max <= r_tail_max;
            r_head_sum <= r_tail_sum;
            if (w_push) begin
              r_tail_min <= w_new_min;
              r_tail_max <= w_new_max;
              r_tail_sum <= w_new_sum;
            end else begin
              r_state <= S_ONE;
            end
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 8'd255)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign out_valid  = (r_state != S_EMPTY);
  assign out_min    = r_head_min;
  assign out_max    = r_head_max;
  assign out_sum    = r_head_sum;
  assign drop_count = r_drop_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_window_stats_tracker.sv
// Bench for window_stats_tracker at WINDOW=4: table-driven windows, a record
// scoreboard popped on each consumer handshake, and hand-written corner sequences.
module tb_window_stats_tracker;

  localparam int WINDOW = 4;
  localparam int SUM_W  = 10;

  logic             clk;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic [7:0]       in_sample;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_min;
  logic [7:0]       out_max;
  logic [SUM_W-1:0] out_sum;
  logic [7:0]       drop_count;
  logic [1:0]       dbg_state;

  window_stats_tracker #(.WINDOW(WINDOW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_min    (out_min),
    .out_max    (out_max),
    .out_sum    (out_sum),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int exp_drop = 0;
  logic [25:0] exp_q[$];

  typedef struct {
    int s[4];
    int exp_min;
    int exp_max;
    int exp_sum;
    bit ready;
    bit exp_drop;
  } win_vec_t;

  win_vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit e, input bit v, input int s);
    en = e;
    in_valid = v;
    in_sample = 8'(s);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] pack_rec(input int mn, input int mx, input int sm);
    return {8'(mn), 8'(mx), 10'(sm)};
  endfunction

  task automatic send_window(input int idx);
    out_ready = tbl[idx].ready;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        if (tbl[idx].exp_drop) exp_drop++;
        else exp_q.push_back(pack_rec(tbl[idx].exp_min, tbl[idx].exp_max, tbl[idx].exp_sum));
      end
      step(1'b1, 1'b1, tbl[idx].s[i]);
    end
  endtask

  // scoreboard: compare the head record on every handshake
  always @(negedge clk) begin
    if (!rst && en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 1, 0);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        check("rec_min", int'($signed(out_min)), int'($signed(e[25:18])));
        check("rec_max", int'($signed(out_max)), int'($signed(e[17:10])));
        check("rec_sum", int'($signed(out_sum)), int'($signed(e[9:0])));
      end
    end
  end

  initial begin
    tbl[0] = '{s: '{3, -5, 7, 1},         exp_min: -5,   exp_max: 7,    exp_sum: 6,    ready: 1, exp_drop: 0};
    tbl[1] = '{s: '{127, 127, 127, 127},  exp_min: 127,  exp_max: 127,  exp_sum: 508,  ready: 1, exp_drop: 0};
    tbl[2] = '{s: '{-128, -128, -128, -128}, exp_min: -128, exp_max: -128, exp_sum: -512, ready: 1, exp_drop: 0};
    tbl[3] = '{s: '{1, 1, 1, 1},          exp_min: 1,    exp_max: 1,    exp_sum: 4,    ready: 0, exp_drop: 0};
    tbl[4] = '{s: '{2, 2, 2, 2},          exp_min: 2,    exp_max: 2,    exp_sum: 8,    ready: 0, exp_drop: 0};
    tbl[5] = '{s: '{3, 3, 3, 3},          exp_min: 3,    exp_max: 3,    exp_sum: 12,   ready: 0, exp_drop: 1};

    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_valid", int'(out_valid), 0);
    check("rst_min", int'(out_min), 0);
    check("rst_max", int'(out_max), 0);
    check("rst_sum", int'(out_sum), 0);
    check("rst_drop", int'(drop_count), 0);
    rst = 1'b0;
    repeat (10) step(1'b1, 1'b0, 0);
    check("idle_valid", int'(out_valid), 0);
    check("idle_sum", int'(out_sum), 0);

    // basic and extreme windows: valid exactly one cycle after completion
    for (int w = 0; w < 3; w++) begin
      send_window(w);
      check($sformatf("lat_valid_w%0d", w), int'(out_valid), 1);
      step(1'b1, 1'b0, 0);
      check($sformatf("one_cycle_w%0d", w), int'(out_valid), 0);
    end
    check("drop_after_basic", int'(drop_count), 0);

    // backpressure: two buffered, third dropped
    for (int w = 3; w < 6; w++) send_window(w);
    check("bp_state_full", int'(dbg_state), 2);
    check("bp_drop", int'(drop_count), 1);
    repeat (3) step(1'b1, 1'b0, 0);
    check("bp_hold_valid", int'(out_valid), 1);
    check("bp_hold_sum", int'($signed(out_sum)), 4);
    out_ready = 1'b1;
    step(1'b1, 1'b0, 0);
    check("bp_pop1_valid", int'(out_valid), 1);
    check("bp_pop1_sum", int'($signed(out_sum)), 8);
    step(1'b1, 1'b0, 0);
    check("bp_empty", int'(out_valid), 0);
    check("bp_hold_last", int'($signed(out_sum)), 8);

    // full buffer with a pop on the completion edge: no drop
    out_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) exp_q.push_back(pack_rec(4 + w, 4 + w, 16 + 4 * w));
        step(1'b1, 1'b1, 4 + w);
      end
    end
    check("fp_full", int'(dbg_state), 2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6);
    out_ready = 1'b1;
    exp_q.push_back(pack_rec(6, 6, 24));
    step(1'b1, 1'b1, 6);
    check("fp_still_full", int'(dbg_state), 2);
    check("fp_no_drop", int'(drop_count), 1);
    repeat (3) step(1'b1, 1'b0, 0);
    check("fp_drained", int'(out_valid), 0);

    // reset mid-window discards the partial window
    step(1'b1, 1'b1, 10);
    step(1'b1, 1'b1, 20);
    rst = 1'b1;
    step(1'b1, 1'b0, 0);
    rst = 1'b0;
    check("mr_drop_cleared", int'(drop_count), 0);
    exp_drop = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(pack_rec(1, 1, 4));
      step(1'b1, 1'b1, 1);
    end
    check("mr_valid", int'(out_valid), 1);
    step(1'b1, 1'b0, 0);

    // en gating: a gated sample is ignored, and a gated cycle does not pop
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 2);
    step(1'b0, 1'b1, 50);
    step(1'b1, 1'b1, 3);
    check("en_no_early", int'(out_valid), 0);
    exp_q.push_back(pack_rec(1, 4, 10));
    step(1'b1, 1'b1, 4);
    check("en_complete", int'(out_valid), 1);
    step(1'b0, 1'b0, 0);
    check("en_no_pop", int'(out_valid), 1);
    step(1'b1, 1'b0, 0);
    check("en_pop", int'(out_valid), 0);

    // bounded drain of anything left in the scoreboard
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b1, 1'b0, 0);
    check("queue_empty", exp_q.size(), 0);
    check("drop_final", int'(drop_count), exp_drop);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
